// File: rtl/rtos_pkg.sv
// Shared RTOS timer parameters and the task-timer FSM state encoding.
package rtos_pkg;

    localparam int NTASKS_DEF = 16;
    localparam int ID_W_DEF   = 8;
    localparam int TICK_W_DEF = 32;

    typedef enum logic {
        SCAN  = 1'b0,
        ISSUE = 1'b1
    } timerState_t;

endpackage

// File: rtl/timer_entry_table.sv
// Per-task wake tick storage and pending bits; one write port, one scan read port.
module timer_entry_table #(
    parameter int NTASKS = 16,
    parameter int TICK_W = 32,
    parameter int PTR_W  = 4
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic                wrEn,
    input  logic                wrSet,
    input  logic [PTR_W-1:0]    wrIdx,
    input  logic [TICK_W-1:0]   wrWake,
    input  logic [PTR_W-1:0]    rdIdx,
    output logic                rdPending,
    output logic [TICK_W-1:0]   rdWake,
    output logic [NTASKS-1:0]   pendingVec
);

    logic [NTASKS-1:0]              pending;
    logic [NTASKS-1:0][TICK_W-1:0]  wake;

    always_ff @(posedge aclk) begin
        if (areset)
            pending <= '0;
        else if (wrEn)
            pending[wrIdx] <= wrSet;
    end

    // Wake values are only meaningful while pending, so they carry no reset.
    always_ff @(posedge aclk) begin
        if (wrEn && wrSet)
            wake[wrIdx] <= wrWake;
    end

    assign rdPending  = pending[rdIdx];
    assign rdWake     = wake[rdIdx];
    assign pendingVec = pending;

endmodule

// File: rtl/task_timer_ctrl.sv
// Task delay timer: round-robin scan of wake ticks, resumes expired tasks via valid/ready.
module task_timer_ctrl
    import rtos_pkg::*;
#(
    parameter int NTASKS = NTASKS_DEF,
    parameter int ID_W   = ID_W_DEF,
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        delayTask_in,
    input  logic                        cancelTask_in,
    input  logic [ID_W-1:0]             idTask_in,
    input  logic [TICK_W-1:0]           valueDelay_in,
    input  logic [TICK_W-1:0]           tickval_in,
    output logic                        resume_tasktimer_out,
    output logic [ID_W-1:0]             idtasktimer_out,
    input  logic                        resume_ready_in,
    output logic [$clog2(NTASKS+1)-1:0] pending_cnt_out,
    output logic                        err_out
);

    localparam int PTR_W = (NTASKS > 1) ? $clog2(NTASKS) : 1;
    localparam int CNT_W = $clog2(NTASKS+1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NTASKS - 1);

    timerState_t        state, stateNext;
    logic [PTR_W-1:0]   ptr, ptrNext, ptrAdv;
    logic               clrPend;
    logic [PTR_W-1:0]   clrIdx;
    logic               errQ;

    logic               idValid, hostWr, hostHitPtr, xfer, expired;
    logic [PTR_W-1:0]   hostIdx;
    logic               wrEn, wrSet;
    logic [PTR_W-1:0]   wrIdx;
    logic [TICK_W-1:0]  wrWake, rdWake, age;
    logic               rdPending;
    logic [NTASKS-1:0]  pendingVec;
    logic [CNT_W-1:0]   cnt;

    assign idValid    = 32'(idTask_in) < 32'(NTASKS);
    assign hostIdx    = idTask_in[PTR_W-1:0];
    assign hostWr     = (delayTask_in | cancelTask_in) & idValid;
    assign hostHitPtr = hostWr && (hostIdx == ptr);
    assign xfer       = (state == ISSUE) && resume_ready_in;
    assign ptrAdv     = (ptr == LAST) ? '0 : ptr + 1'b1;

    // Signed age: expired once the tick has reached or passed wake, across wrap.
    assign age     = tickval_in - rdWake;
    assign expired = rdPending && !age[TICK_W-1];

    // Host requests own the write port; a transfer clear that collides with one
    // is parked in clrPend and written on the next free cycle.
    always_comb begin
        wrEn   = 1'b0;
        wrSet  = 1'b0;
        wrIdx  = ptr;
        wrWake = tickval_in + valueDelay_in;
        if (hostWr) begin
            wrEn  = 1'b1;
            wrSet = delayTask_in;
            wrIdx = hostIdx;
        end else if (clrPend) begin
            wrEn  = 1'b1;
            wrIdx = clrIdx;
        end else if (xfer) begin
            wrEn  = 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        case (state)
            SCAN: begin
                // Hold while a parked clear or a same-cycle write makes the read stale.
                if (!clrPend && !hostHitPtr) begin
                    if (expired) stateNext = ISSUE;
                    else         ptrNext   = ptrAdv;
                end
            end
            ISSUE: begin
                if (xfer) begin
                    stateNext = SCAN;
                    ptrNext   = ptrAdv;
                end else if (hostHitPtr) begin
                    stateNext = SCAN;
                end
            end
            default: stateNext = SCAN;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= SCAN;
            ptr     <= '0;
            clrPend <= 1'b0;
            clrIdx  <= '0;
            errQ    <= 1'b0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            errQ  <= (delayTask_in | cancelTask_in) & ~idValid;
            if (xfer && hostWr && (hostIdx != ptr)) begin
                clrPend <= 1'b1;
                clrIdx  <= ptr;
            end else if (clrPend && (!hostWr || hostIdx == clrIdx)) begin
                clrPend <= 1'b0;
            end
        end
    end

    timer_entry_table #(
        .NTASKS (NTASKS),
        .TICK_W (TICK_W),
        .PTR_W  (PTR_W)
    ) uTable (
        .aclk       (aclk),
        .areset     (areset),
        .wrEn       (wrEn),
        .wrSet      (wrSet),
        .wrIdx      (wrIdx),
        .wrWake     (wrWake),
        .rdIdx      (ptr),
        .rdPending  (rdPending),
        .rdWake     (rdWake),
        .pendingVec (pendingVec)
    );

    always_comb begin
        cnt = '0;
        for (int i = 0; i < NTASKS; i++)
            cnt = cnt + CNT_W'(pendingVec[i]);
    end

    assign pending_cnt_out      = cnt;
    assign resume_tasktimer_out = (state == ISSUE);
    assign idtasktimer_out      = (state == ISSUE) ? ID_W'(ptr) : '0;
    assign err_out              = errQ;

endmodule

// File: tb/tb_task_timer_ctrl.sv
// Directed bench for task_timer_ctrl: expiry timing, wrap, backpressure, cancel, errors, reset.
module tb_task_timer_ctrl;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        delayTask_in = 1'b0;
    logic        cancelTask_in = 1'b0;
    logic [7:0]  idTask_in = '0;
    logic [31:0] valueDelay_in = '0;
    logic [31:0] tickval_in = '0;
    logic        resume_ready_in = 1'b1;
    logic        resume_tasktimer_out;
    logic [7:0]  idtasktimer_out;
    logic [4:0]  pending_cnt_out;
    logic        err_out;

    int          total = 0;
    int          passed = 0;
    int          xferCnt = 0;
    int          x0;
    logic [7:0]  lastId = '0;
    logic        f;
    logic [7:0]  id;
    logic [31:0] tk, w;

    task_timer_ctrl dut (
        .aclk                 (aclk),
        .areset               (areset),
        .delayTask_in         (delayTask_in),
        .cancelTask_in        (cancelTask_in),
        .idTask_in            (idTask_in),
        .valueDelay_in        (valueDelay_in),
        .tickval_in           (tickval_in),
        .resume_tasktimer_out (resume_tasktimer_out),
        .idtasktimer_out      (idtasktimer_out),
        .resume_ready_in      (resume_ready_in),
        .pending_cnt_out      (pending_cnt_out),
        .err_out              (err_out)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (resume_tasktimer_out && resume_ready_in) begin
            xferCnt++;
            lastId = idtasktimer_out;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
        tickval_in = tickval_in + 1;
    endtask

    task automatic req(input logic d, input logic c, input logic [7:0] rid, input logic [31:0] v);
        delayTask_in  = d;
        cancelTask_in = c;
        idTask_in     = rid;
        valueDelay_in = v;
        cyc();
        delayTask_in  = 1'b0;
        cancelTask_in = 1'b0;
    endtask

    // tk is the tick at which the issuing entry was examined (one cycle before valid).
    task automatic waitResume(input int maxc, output logic found, output logic [7:0] rid,
                              output logic [31:0] rtk);
        found = 1'b0;
        rid   = '0;
        rtk   = '0;
        for (int i = 0; i < maxc; i++) begin
            if (resume_tasktimer_out) begin
                found = 1'b1;
                rid   = idtasktimer_out;
                rtk   = tickval_in - 1;
                break;
            end
            cyc();
        end
    endtask

    initial begin
        cyc();
        cyc();
        chk("rstValid", resume_tasktimer_out, 0);
        chk("rstId", idtasktimer_out, 0);
        chk("rstCnt", pending_cnt_out, 0);
        chk("rstErr", err_out, 0);
        areset = 1'b0;

        // Basic delay: wake 0xAA + 0x69 = 0x113
        tickval_in = 32'hAA;
        req(1, 0, 1, 32'h69);
        chk("t1CntSet", pending_cnt_out, 1);
        waitResume(400, f, id, tk);
        chk("t1Found", f, 1);
        chk("t1Id", id, 1);
        chk("t1Window", (tk >= 32'h113) && (tk <= 32'h123), 1);
        x0 = xferCnt;
        cyc();
        chk("t1Xfer", xferCnt, x0 + 1);
        chk("t1CntClr", pending_cnt_out, 0);
        chk("t1ValidLow", resume_tasktimer_out, 0);

        // Wrap: wake 0xFFFFFFF0 + 0x20 = 0x10
        tickval_in = 32'hFFFF_FFF0;
        req(1, 0, 3, 32'h20);
        waitResume(100, f, id, tk);
        chk("t2Found", f, 1);
        chk("t2Id", id, 3);
        chk("t2Window", (tk >= 32'h10) && (tk <= 32'h20), 1);
        cyc();

        // Backpressure: id0 held in ISSUE anchors the pointer, then 2 and 3 expire together
        resume_ready_in = 1'b0;
        req(1, 0, 0, 0);
        waitResume(40, f, id, tk);
        chk("t3Id0", id, 0);
        req(1, 0, 2, 0);
        req(1, 0, 3, 0);
        chk("t3Cnt3", pending_cnt_out, 3);
        chk("t3HoldId0", {resume_tasktimer_out, idtasktimer_out}, {1'b1, 8'd0});
        x0 = xferCnt;
        resume_ready_in = 1'b1;
        cyc();
        resume_ready_in = 1'b0;
        chk("t3Xfer0", {xferCnt[7:0], lastId}, {8'(x0 + 1), 8'd0});
        waitResume(40, f, id, tk);
        chk("t3FirstId2", id, 2);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3Stable2", {resume_tasktimer_out, idtasktimer_out}, {1'b1, 8'd2});
        end
        resume_ready_in = 1'b1;
        cyc();
        chk("t3Xfer2", lastId, 2);
        waitResume(40, f, id, tk);
        chk("t3NextId3", id, 3);
        cyc();
        chk("t3Xfer3", {xferCnt[7:0], lastId}, {8'(x0 + 3), 8'd3});
        chk("t3CntZero", pending_cnt_out, 0);

        // Re-delay during ISSUE cancels the issue
        resume_ready_in = 1'b0;
        req(1, 0, 0, 0);
        waitResume(40, f, id, tk);
        chk("t4Issue0", {f, id}, {1'b1, 8'd0});
        x0 = xferCnt;
        w  = tickval_in + 32'h59;
        req(1, 0, 0, 32'h59);
        chk("t4ValidDrop", resume_tasktimer_out, 0);
        chk("t4CntKept", pending_cnt_out, 1);
        resume_ready_in = 1'b1;
        waitResume(200, f, id, tk);
        chk("t4Reissue", {f, id}, {1'b1, 8'd0});
        chk("t4Window", (tk >= w) && (tk <= w + 16), 1);
        chk("t4NoXferYet", xferCnt, x0);
        cyc();
        chk("t4Xfer", xferCnt, x0 + 1);

        // Out-of-range id, cancel, and delay-beats-cancel
        req(1, 0, 8'h20, 5);
        chk("t5ErrPulse", err_out, 1);
        chk("t5CntSame", pending_cnt_out, 0);
        cyc();
        chk("t5ErrClr", err_out, 0);
        req(1, 0, 1, 32'h30);
        chk("t5CntSet", pending_cnt_out, 1);
        req(0, 1, 1, 0);
        chk("t5CntCancel", pending_cnt_out, 0);
        waitResume(100, f, id, tk);
        chk("t5NoResume", f, 0);
        req(1, 1, 5, 8);
        chk("t5DelayWins", pending_cnt_out, 1);
        waitResume(60, f, id, tk);
        chk("t5Id5", {f, id}, {1'b1, 8'd5});
        cyc();

        // Reset mid-ISSUE, with a bad-id request in the same cycle
        resume_ready_in = 1'b0;
        req(1, 0, 4, 0);
        waitResume(40, f, id, tk);
        chk("t6Issue", {f, id}, {1'b1, 8'd4});
        x0 = xferCnt;
        areset = 1'b1;
        delayTask_in = 1'b1;
        idTask_in = 8'h30;
        cyc();
        areset = 1'b0;
        delayTask_in = 1'b0;
        chk("t6Valid", resume_tasktimer_out, 0);
        chk("t6Id", idtasktimer_out, 0);
        chk("t6Cnt", pending_cnt_out, 0);
        chk("t6Err", err_out, 0);
        chk("t6NoXfer", xferCnt, x0);
        resume_ready_in = 1'b1;
        waitResume(40, f, id, tk);
        chk("t6Cleared", f, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
